// File: rtl/prll_bus_rr_n_if.sv
// Driver-side bus of prll_bus_rr_n: per-driver transmit FIFO heads, receive FIFO
// status and the strobes/data the arbiter returns to them.
interface prll_bus_rr_n_if #(
    parameter int BITS  = 32,
    parameter int DRVRS = 4
);
    logic [DRVRS-1:0]      pndng;
    logic [DRVRS*BITS-1:0] D_pop;
    logic [DRVRS-1:0]      pop;
    logic [DRVRS-1:0]      full;
    logic [DRVRS-1:0]      push;
    logic [DRVRS*BITS-1:0] D_push;

    // Arbiter side
    modport master (
        input  pndng, D_pop, full,
        output pop, push, D_push
    );

    // Driver FIFO side
    modport slave (
        output pndng, D_pop, full,
        input  pop, push, D_push
    );
endinterface

// File: rtl/prll_bus_rr_n.sv
// N-driver parallel bus: round-robin grant, one message per transaction,
// addressed or broadcast delivery held off until every target can accept it.
module prll_bus_rr_n #(
    parameter int         BITS      = 32,
    parameter int         DRVRS     = 4,
    parameter logic [7:0] BROADCAST = 8'hFF
) (
    input  logic                   clk,
    input  logic                   reset,
    prll_bus_rr_n_if.master        bus,
    output logic [3:0]             grant_id,
    output logic                   busy,
    output logic [15:0]            msg_cnt,
    output logic [7:0]             drop_cnt
);
    typedef enum logic [1:0] {IDLE, POP, ROUTE, PUSH} state_t;

    state_t           state_reg, state_next;
    logic [3:0]       grant_reg, grant_next;
    logic [3:0]       last_reg, last_next;
    logic [DRVRS-1:0] pop_reg, pop_next;
    logic [DRVRS-1:0] push_reg, push_next;
    logic [BITS-1:0]  bus_reg, bus_next;
    logic [BITS-1:0]  word_reg, word_next;
    logic             busy_reg, busy_next;
    logic [15:0]      msg_reg, msg_next;
    logic [7:0]       drop_reg, drop_next;

    logic [BITS-1:0]  head_word [16];
    logic [15:0]      pndng_ext;
    logic [7:0]       target;
    logic             route_bcast, route_valid;
    logic [DRVRS-1:0] route_mask;
    logic [DRVRS-1:0] grant_onehot;
    logic             rr_found;
    logic [3:0]       rr_idx;
    int               rr_pos;

    // Padded to 16 entries so a 4-bit grant index is always in range
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_head
            if (gi < DRVRS) begin : g_used
                assign head_word[gi] = bus.D_pop[gi*BITS +: BITS];
            end else begin : g_unused
                assign head_word[gi] = '0;
            end
        end
    endgenerate

    assign pndng_ext   = 16'(bus.pndng);
    assign target      = bus_reg[BITS-1 -: 8];
    assign route_bcast = (target == BROADCAST);
    assign route_valid = route_bcast || (int'(target) < DRVRS);

    generate
        for (genvar gi = 0; gi < DRVRS; gi++) begin : g_mask
            assign route_mask[gi]   = route_bcast ? (grant_reg != 4'(gi)) : (target == 8'(gi));
            assign grant_onehot[gi] = (rr_idx == 4'(gi));
        end
    endgenerate

    // Scan downward so the requester closest after last_reg is the one kept
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = last_reg;
        rr_pos   = 0;
        for (int k = DRVRS; k >= 1; k--) begin
            rr_pos = (int'(last_reg) + k) % DRVRS;
            if (pndng_ext[4'(rr_pos)]) begin
                rr_found = 1'b1;
                rr_idx   = 4'(rr_pos);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        last_next  = last_reg;
        pop_next   = '0;
        push_next  = '0;
        bus_next   = bus_reg;
        word_next  = word_reg;
        msg_next   = msg_reg;
        drop_next  = drop_reg;
        case (state_reg)
            IDLE: begin
                if (rr_found) begin
                    grant_next = rr_idx;
                    pop_next   = grant_onehot;
                    state_next = POP;
                end
            end
            POP: begin
                bus_next   = head_word[grant_reg];
                last_next  = grant_reg;
                state_next = ROUTE;
            end
            ROUTE: begin
                if (!route_valid) begin
                    if (drop_reg != 8'hFF) drop_next = drop_reg + 8'd1;
                    state_next = IDLE;
                end else if ((bus.full & route_mask) == '0) begin
                    // Whole mask at once: a broadcast never partially delivers
                    push_next  = route_mask;
                    word_next  = bus_reg;
                    state_next = PUSH;
                end
            end
            PUSH: begin
                msg_next   = msg_reg + 16'd1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            last_reg  <= 4'(DRVRS - 1);
            pop_reg   <= '0;
            push_reg  <= '0;
            bus_reg   <= '0;
            word_reg  <= '0;
            busy_reg  <= 1'b0;
            msg_reg   <= '0;
            drop_reg  <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            last_reg  <= last_next;
            pop_reg   <= pop_next;
            push_reg  <= push_next;
            bus_reg   <= bus_next;
            word_reg  <= word_next;
            busy_reg  <= busy_next;
            msg_reg   <= msg_next;
            drop_reg  <= drop_next;
        end
    end

    assign bus.pop    = pop_reg;
    assign bus.push   = push_reg;
    assign bus.D_push = {DRVRS{word_reg}};
    assign grant_id   = grant_reg;
    assign busy       = busy_reg;
    assign msg_cnt    = msg_reg;
    assign drop_cnt   = drop_reg;
endmodule
